// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: the state encoding and the grant helper.
// The state encoding is shared with the UART controller, so keep these values fixed.
package uart_tx_arbiter_pkg;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_GNT0 = 2'd1;
  localparam logic [ST_W-1:0] ST_GNT1 = 2'd2;

  typedef enum logic [ST_W-1:0] {
    IDLE = ST_IDLE,
    GNT0 = ST_GNT0,
    GNT1 = ST_GNT1
  } arb_state_t;

  function automatic arb_state_t gnt_state(input logic id);
    return id ? GNT1 : GNT0;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/FIFO bundle for the UART TX arbiter.
// The master side is the requesters plus the FIFO; the slave side is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int B = 8
);

  logic         req0_valid;
  logic [B-1:0] req0_data;
  logic         req0_last;
  logic         req0_ready;
  logic         req1_valid;
  logic [B-1:0] req1_data;
  logic         req1_last;
  logic         req1_ready;
  logic         fifo_full;
  logic         fifo_wr;
  logic [B-1:0] fifo_w_data;
  logic         busy;
  logic         gnt_id;
  logic         timeout;

  modport master (
    output req0_valid, req0_data, req0_last,
    output req1_valid, req1_data, req1_last,
    output fifo_full,
    input  req0_ready, req1_ready, fifo_wr, fifo_w_data, busy, gnt_id, timeout
  );

  modport slave (
    input  req0_valid, req0_data, req0_last,
    input  req1_valid, req1_data, req1_last,
    input  fifo_full,
    output req0_ready, req1_ready, fifo_wr, fifo_w_data, busy, gnt_id, timeout
  );

endinterface

// File: rtl/uart_arb_timer.sv
// Idle-grant timeout counter for the UART TX arbiter.
// Present only when UART_ARB_TIMEOUT_EN is defined.
`ifdef UART_ARB_TIMEOUT_EN
module uart_arb_timer #(
  parameter int TMO_W   = 4,
  parameter int TMO_MAX = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [TMO_W-1:0] tmo_cnt;

  assign expired = (tmo_cnt == TMO_W'(TMO_MAX));

  // Saturates at TMO_MAX so a stalled revoke never wraps back to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (clr) begin
      tmo_cnt <= '0;
    end else if (inc && !expired) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART TX FIFO write port between two sources.
// Define UART_ARB_TIMEOUT_EN to revoke a grant that sits idle for TMO_MAX+1 cycles.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int B       = 8,
  parameter int TMO_W   = 4,
  parameter int TMO_MAX = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_tx_arbiter_if.slave  bus
);

  if (TMO_MAX >= (1 << TMO_W)) begin : g_bad_tmo_cfg
    $error("uart_tx_arbiter: TMO_MAX must be below 2**TMO_W");
  end

  arb_state_t   state;
  arb_state_t   state_next;
  logic         prio;
  logic         prio_next;
  logic         granted;
  logic         gnt;
  logic         cur_valid;
  logic         cur_last;
  logic [B-1:0] cur_data;
  logic         accept;
  logic         tmo_expired;

  assign granted   = (state != IDLE);
  assign gnt       = (state == GNT1);
  assign cur_valid = gnt ? bus.req1_valid : bus.req0_valid;
  assign cur_last  = gnt ? bus.req1_last  : bus.req0_last;
  assign cur_data  = gnt ? bus.req1_data  : bus.req0_data;
  assign accept    = granted && cur_valid && !bus.fifo_full;

`ifdef UART_ARB_TIMEOUT_EN
  // Counter is held clear in IDLE so every new grant starts from zero.
  uart_arb_timer #(
    .TMO_W   (TMO_W),
    .TMO_MAX (TMO_MAX)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!granted || accept),
    .inc     (granted && !cur_valid),
    .expired (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      prio  <= 1'b0;
    end else begin
      state <= state_next;
      prio  <= prio_next;
    end
  end

  always_comb begin
    state_next      = state;
    prio_next       = prio;
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    bus.fifo_wr     = 1'b0;
    bus.fifo_w_data = '0;
    bus.timeout     = 1'b0;
    bus.busy        = granted;
    bus.gnt_id      = gnt;

    case (state)
      IDLE: begin
        if (bus.req0_valid && bus.req1_valid) begin
          state_next = gnt_state(prio);
        end else if (bus.req0_valid) begin
          state_next = GNT0;
        end else if (bus.req1_valid) begin
          state_next = GNT1;
        end
      end

      GNT0, GNT1: begin
        if (gnt) begin
          bus.req1_ready = !bus.fifo_full;
        end else begin
          bus.req0_ready = !bus.fifo_full;
        end
        bus.fifo_wr = accept;
        if (accept) begin
          bus.fifo_w_data = cur_data;
        end
        // Handing priority to the other source gives strict alternation under contention.
        if (accept && cur_last) begin
          state_next = IDLE;
          prio_next  = !gnt;
        end else if (tmo_expired && !cur_valid) begin
          state_next  = IDLE;
          prio_next   = !gnt;
          bus.timeout = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
